// File: rtl/generic_2clk_fifo_pkg.sv
// -----------------------------------------------------------------------------
// generic_2clk_fifo_pkg
// Shared definitions for the dual-clock RAM FIFO envelope:
//   - rd_state_e      : read-side sequencer state encoding
//   - RD_LATENCY_MIN/MAX : supported RAM read latency range
//   - clamp_rd_latency : folds an out-of-range latency into the supported range
// -----------------------------------------------------------------------------
package generic_2clk_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic int clamp_rd_latency(input int lat);
        if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
        if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/generic_fifo_rd_obuf.sv
// -----------------------------------------------------------------------------
// generic_fifo_rd_obuf
// Small synchronous output buffer (circular, FIFO order) for the read sequencer.
// Head data comes straight from a storage register, so there is no
// combinational path from push_data_i to head_data_o.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears storage too)
//   clear_i      : synchronous clear of all entries (has priority over push/pop)
//   push_i       : write push_data_i; ignored when full unless popping same cycle
//   push_data_i  : word to store
//   pop_i        : drop head entry; ignored when empty
//   head_data_o  : oldest stored word
//   level_o      : number of occupied entries
// -----------------------------------------------------------------------------
module generic_fifo_rd_obuf #(
    parameter int DAT_WIDTH = 32,
    parameter int BUF_DEPTH = 2,
    parameter int LVL_WIDTH = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DAT_WIDTH-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [DAT_WIDTH-1:0] head_data_o,
    output logic [LVL_WIDTH-1:0] level_o
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(BUF_DEPTH - 1);

    logic [DAT_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LVL_WIDTH-1:0] level_q;
    logic [LVL_WIDTH-1:0] level_d;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (level_q != '0);
    // A push into a full buffer is allowed when the head leaves in the same cycle.
    assign do_push = push_i && ((level_q != LVL_WIDTH'(BUF_DEPTH)) || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            level_q <= level_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign level_o     = level_q;

endmodule

// File: rtl/generic_2clk_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// generic_2clk_fifo_rd_ctrl
// Read-side sequencer (rd_clk domain) of the dual-clock RAM FIFO. Pops the FIFO,
// tracks RAM reads in flight, captures returning data into a small output
// buffer and presents it as a valid/ready stream. Also provides enable/idle
// control and a flush sequence that empties the FIFO and discards its data.
//
// Handshake: a word transfers on every cycle with out_valid & out_ready high;
// out_data is stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk, reset          : rd clock, asynchronous active-high reset
//   enable              : 1 = fetch from FIFO, 0 = stop issuing pops
//   flush               : one-cycle pulse, start the drain sequence
//   fifo_rd_op          : pop strobe to FIFO rd_op / RAM read enable
//   fifo_rd_empty       : FIFO empty flag
//   fifo_rd_entry_used  : FIFO occupancy (lags fifo_rd_op by one cycle)
//   fifo_rd_data        : RAM read data, valid RD_LATENCY cycles after a pop
//   out_valid/out_ready/out_data : output stream
//   buf_level           : occupied output buffer entries
//   idle                : IDLE, nothing in flight, buffer empty
//   flush_done          : one-cycle pulse at the end of a drain
//   err_overrun         : sticky, read data returned while the buffer was full
//   dbg_state           : current sequencer state (rd_state_e encoding)
// -----------------------------------------------------------------------------
module generic_2clk_fifo_rd_ctrl
    import generic_2clk_fifo_pkg::*;
#(
    parameter int DAT_WIDTH  = 32,
    parameter int PTR_WIDTH  = 9,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           flush,
    output logic                           fifo_rd_op,
    input  logic                           fifo_rd_empty,
    input  logic [PTR_WIDTH:0]             fifo_rd_entry_used,
    input  logic [DAT_WIDTH-1:0]           fifo_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DAT_WIDTH-1:0]           out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level,
    output logic                           idle,
    output logic                           flush_done,
    output logic                           err_overrun,
    output logic [1:0]                     dbg_state
);

    localparam int LAT = clamp_rd_latency(RD_LATENCY);
    localparam int LW  = $clog2(BUF_DEPTH + 1);
    localparam int IW  = $clog2(LAT + 1);
    localparam int CW  = LW + 2;

    rd_state_e     state_q, state_d;
    logic          rd_op_q;
    logic [LAT-1:0] pipe_q, pipe_d;
    logic          err_q;
    logic          rst_done_q;
    logic [LW-1:0] level;
    logic [IW-1:0] inflight;
    logic          avail_nz;
    logic          can_pop;
    logic          credit_ok;
    logic          tail;
    logic          pop;
    logic          full;
    logic          push;
    logic          overrun;
    logic          clear;
    logic [CW-1:0] occ;
    logic [CW-1:0] limit;

    // entry_used has not yet seen last cycle's pop, so subtract it; a plain
    // compare avoids a wrap when entry_used is already 0.
    assign avail_nz  = fifo_rd_entry_used > {{PTR_WIDTH{1'b0}}, rd_op_q};
    assign can_pop   = !fifo_rd_empty && avail_nz;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + IW'(pipe_q[i]);
    end

    assign tail      = pipe_q[LAT-1];
    assign out_valid = (state_q != ST_FLUSH) && (level != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (level == LW'(BUF_DEPTH));
    assign push      = tail && (state_q != ST_FLUSH) && (!full || pop);
    assign overrun   = tail && (state_q != ST_FLUSH) && full && !pop;

    // Credit check: every buffered or in-flight word needs a slot; a word
    // leaving this cycle frees its slot immediately.
    assign occ       = CW'(level) + CW'(inflight);
    assign limit     = CW'(BUF_DEPTH) + CW'(pop);
    assign credit_ok = occ < limit;

    always_comb begin
        state_d    = state_q;
        fifo_rd_op = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush)       state_d = ST_FLUSH;
                else if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                fifo_rd_op = can_pop && enable && credit_ok;
                if (flush)                           state_d = ST_FLUSH;
                else if (!enable && inflight == '0) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                fifo_rd_op = can_pop;
                if (fifo_rd_entry_used == '0 && inflight == '0 && level == '0) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffered words are thrown away on the way into FLUSH.
    assign clear = (state_q != ST_FLUSH) && (state_d == ST_FLUSH);

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = fifo_rd_op;
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_op_q    <= 1'b0;
            pipe_q     <= '0;
            err_q      <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_op_q    <= fifo_rd_op;
            pipe_q     <= pipe_d;
            rst_done_q <= 1'b1;
            if (overrun) err_q <= 1'b1;
        end
    end

    generic_fifo_rd_obuf #(
        .DAT_WIDTH (DAT_WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .LVL_WIDTH (LW)
    ) u_obuf (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .pop_i       (pop),
        .head_data_o (out_data),
        .level_o     (level)
    );

    // rst_done_q keeps idle low while reset is held, so every output reads 0.
    assign idle        = rst_done_q && (state_q == ST_IDLE) && (inflight == '0) && (level == '0);
    assign buf_level   = level;
    assign err_overrun = err_q;
    assign dbg_state   = state_q;

endmodule
